// File: rtl/wbu_host_mux_if.sv
// rtl/wbu_host_mux_if.sv - byte ports, serial tx/rx and demuxed receive streams of the host mux
interface wbu_host_mux_if;
  logic       i_cmd_stb;
  logic [6:0] i_cmd_data;
  logic       o_cmd_busy;
  logic       i_con_stb;
  logic [6:0] i_con_data;
  logic       o_con_busy;
  logic       o_tx_stb;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;
  logic       i_rx_stb;
  logic [7:0] i_rx_data;
  logic       o_rcmd_valid;
  logic [6:0] o_rcmd_data;
  logic       i_rcmd_ready;
  logic       o_rcon_valid;
  logic [6:0] o_rcon_data;
  logic       i_rcon_ready;
  logic [1:0] o_ovfl;
  logic       i_clr_ovfl;

  modport slave (
    input  i_cmd_stb, i_cmd_data, i_con_stb, i_con_data, i_tx_busy,
    input  i_rx_stb, i_rx_data, i_rcmd_ready, i_rcon_ready, i_clr_ovfl,
    output o_cmd_busy, o_con_busy, o_tx_stb, o_tx_data,
    output o_rcmd_valid, o_rcmd_data, o_rcon_valid, o_rcon_data, o_ovfl
  );

  modport master (
    output i_cmd_stb, i_cmd_data, i_con_stb, i_con_data, i_tx_busy,
    output i_rx_stb, i_rx_data, i_rcmd_ready, i_rcon_ready, i_clr_ovfl,
    input  o_cmd_busy, o_con_busy, o_tx_stb, o_tx_data,
    input  o_rcmd_valid, o_rcmd_data, o_rcon_valid, o_rcon_data, o_ovfl
  );
endinterface

// File: rtl/wbu_host_mux.sv
// rtl/wbu_host_mux.sv - command/console channel mux onto one serial byte link, with demux FIFOs
module wbu_host_mux_fifo #(
  parameter int LGFIFO = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_push,
  input  logic [6:0] i_data,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [6:0] o_data,
  output logic       o_drop
);
  localparam int DEPTH = 1 << LGFIFO;
  localparam logic [LGFIFO:0] FULL_CNT = (LGFIFO+1)'(DEPTH);

  logic [6:0]        r_mem [DEPTH];
  logic [LGFIFO-1:0] r_wptr;
  logic [LGFIFO-1:0] r_rptr;
  logic [LGFIFO:0]   r_count;
  logic              w_full;
  logic              w_pop;
  logic              w_write;

  assign w_full  = (r_count == FULL_CNT);
  assign o_valid = (r_count != '0);
  assign w_pop   = o_valid && i_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_write = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;
  assign o_data  = o_valid ? r_mem[r_rptr] : 7'd0;

  always_ff @(posedge i_clk) begin
    if (w_write) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_write) r_wptr <= r_wptr + LGFIFO'(1);
      if (w_pop)   r_rptr <= r_rptr + LGFIFO'(1);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + (LGFIFO+1)'(1);
        2'b01:   r_count <= r_count - (LGFIFO+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module wbu_host_mux #(
  parameter int LGFIFO     = 2,
  parameter bit ROUNDROBIN = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  wbu_host_mux_if.slave bus
);
  logic       r_full;
  logic [7:0] r_hold;
  logic       r_last_cmd;
  logic       w_free;
  logic       w_cmd_pref;
  logic       w_con_pref;
  logic       w_cmd_grant;
  logic       w_con_grant;
  logic       w_cmd_drop;
  logic       w_con_drop;
  logic [1:0] r_ovfl;

  assign w_free = !r_full || !bus.i_tx_busy;

  // "Would win" is evaluated whether or not the channel is asking, so busy is valid with stb low.
  assign w_cmd_pref = ROUNDROBIN ? (!bus.i_con_stb || !r_last_cmd) : 1'b1;
  assign w_con_pref = ROUNDROBIN ? (!bus.i_cmd_stb || r_last_cmd) : !bus.i_cmd_stb;

  assign bus.o_cmd_busy = !(w_free && w_cmd_pref);
  assign bus.o_con_busy = !(w_free && w_con_pref);
  assign w_cmd_grant    = bus.i_cmd_stb && w_free && w_cmd_pref;
  assign w_con_grant    = bus.i_con_stb && w_free && w_con_pref;

  assign bus.o_tx_stb  = r_full;
  assign bus.o_tx_data = r_hold;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_full     <= 1'b0;
      r_hold     <= 8'd0;
      r_last_cmd <= 1'b0;
    end else if (w_free) begin
      if (w_cmd_grant) begin
        r_full     <= 1'b1;
        r_hold     <= {1'b1, bus.i_cmd_data};
        r_last_cmd <= 1'b1;
      end else if (w_con_grant) begin
        r_full     <= 1'b1;
        r_hold     <= {1'b0, bus.i_con_data};
        r_last_cmd <= 1'b0;
      end else begin
        r_full <= 1'b0;
      end
    end
  end

  wbu_host_mux_fifo #(.LGFIFO(LGFIFO)) u_cmd_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (bus.i_rx_stb && bus.i_rx_data[7]),
    .i_data    (bus.i_rx_data[6:0]),
    .i_ready   (bus.i_rcmd_ready),
    .o_valid   (bus.o_rcmd_valid),
    .o_data    (bus.o_rcmd_data),
    .o_drop    (w_cmd_drop)
  );

  wbu_host_mux_fifo #(.LGFIFO(LGFIFO)) u_con_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (bus.i_rx_stb && !bus.i_rx_data[7]),
    .i_data    (bus.i_rx_data[6:0]),
    .i_ready   (bus.i_rcon_ready),
    .o_valid   (bus.o_rcon_valid),
    .o_data    (bus.o_rcon_data),
    .o_drop    (w_con_drop)
  );

  // A fresh overflow outranks a clear arriving in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ovfl <= 2'b00;
    end else begin
      r_ovfl[1] <= w_cmd_drop || (r_ovfl[1] && !bus.i_clr_ovfl);
      r_ovfl[0] <= w_con_drop || (r_ovfl[0] && !bus.i_clr_ovfl);
    end
  end

  assign bus.o_ovfl = r_ovfl;
endmodule

// File: doc/wbu_host_mux.md
WBU_HOST_MUX -- requirements
Module: wbuhostmux

Interface
REQ-001 Parameter LGFIFO, default 2, SHALL set the depth of each receive FIFO to 2^LGFIFO entries of 7 bits.
REQ-002 Parameter ROUNDROBIN, default 1'b1, SHALL select transmit arbitration: 1 = alternating fair, 0 = fixed command priority.
REQ-003 i_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 i_reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_cmd_stb  in  1, i_cmd_data  in  7, o_cmd_busy  out  1 SHALL form the outgoing command-channel byte port.
REQ-006 i_con_stb  in  1, i_con_data  in  7, o_con_busy  out  1 SHALL form the outgoing console-channel byte port.
REQ-007 o_tx_stb  out  1, o_tx_data  out  8, i_tx_busy  in  1 SHALL form the muxed serial transmit port.
REQ-008 i_rx_stb  in  1, i_rx_data  in  8 SHALL form the muxed serial receive port; it has no back-pressure.
REQ-009 o_rcmd_valid  out  1, o_rcmd_data  out  7, i_rcmd_ready  in  1 SHALL form the demuxed command receive stream.
REQ-010 o_rcon_valid  out  1, o_rcon_data  out  7, i_rcon_ready  in  1 SHALL form the demuxed console receive stream.
REQ-011 o_ovfl  out  2 SHALL be sticky overflow flags, bit 1 = command FIFO, bit 0 = console FIFO; i_clr_ovfl  in  1 SHALL clear both.

Function
REQ-012 A byte port handshake SHALL complete in any cycle with stb high and busy low; stb and data SHALL be held by the source until then.
REQ-013 The transmit path SHALL use one 8-bit holding register; o_tx_stb SHALL equal its full flag and o_tx_data its contents.
REQ-014 The holding register SHALL be considered free in a cycle when empty, or when full and i_tx_busy is low (drains that cycle).
REQ-015 When free, a command grant SHALL load {1'b1, i_cmd_data}; a console grant SHALL load {1'b0, i_con_data}; with no grant the register SHALL empty.
REQ-016 Only one channel SHALL be granted per cycle; a lone requester SHALL always win when the register is free.
REQ-017 With both requesting and ROUNDROBIN=1, the channel not granted most recently SHALL win; with ROUNDROBIN=0 command SHALL win.
REQ-018 o_cmd_busy SHALL be high unless the register is free and command would win; o_con_busy likewise; busy SHALL be combinational and valid even when stb is low.
REQ-019 Back-to-back grants SHALL sustain one byte per cycle while i_tx_busy stays low.
REQ-020 A received byte with i_rx_data[7]=1 SHALL push i_rx_data[6:0] into the command FIFO; bit 7=0 SHALL push into the console FIFO.
REQ-021 Each FIFO SHALL output valid = non-empty and data = head entry; a pop SHALL occur when valid and ready are both high.
REQ-022 A pushed byte SHALL appear on its valid output no earlier than the cycle after i_rx_stb, with no combinational path from i_rx_* to any output.
REQ-023 A push into a full FIFO with no same-cycle pop SHALL drop the byte and set the matching o_ovfl bit; contents SHALL be unchanged.
REQ-024 A push into a full FIFO with a same-cycle pop SHALL succeed; count SHALL stay at full.
REQ-025 Read and write pointers SHALL wrap modulo 2^LGFIFO; occupancy SHALL be tracked with an LGFIFO+1-bit count.
REQ-026 i_clr_ovfl SHALL clear o_ovfl next cycle; a simultaneous new overflow SHALL take precedence and set its bit.

Reset
REQ-027 On i_reset_n low, asynchronously: holding register empty, o_tx_stb 0, o_tx_data 0, both FIFOs empty, o_rcmd_valid/o_rcon_valid 0, o_ovfl 0.
REQ-028 Reset SHALL set the last-granted record to console so the first contested grant goes to command.
REQ-029 Reset asserted mid-transfer SHALL abandon the held byte and all FIFO contents; no byte SHALL emerge after release.

Verification
REQ-030 Both stb high, cmd 0x41, con 0x42, i_tx_busy low, ROUNDROBIN=1 -> o_tx_data 0xC1 then 0x42 on consecutive cycles, then the next contested grant goes to command.
REQ-031 i_tx_busy held high 5 cycles with byte 0xC1 held -> o_tx_stb high, data stable, both busy high; busy drops in the cycle i_tx_busy falls.
REQ-032 i_rx bytes 0x85, 0x23, 0x86 -> rcmd stream 0x05, 0x06; rcon stream 0x23; order preserved per channel.
REQ-033 LGFIFO=2, ready low, six rx bytes 0x81..0x86 -> rcmd holds 0x01..0x04, o_ovfl = 2'b10; i_clr_ovfl -> 2'b00.
REQ-034 FIFO full, i_rcmd_ready high and rx 0x87 same cycle -> 0x01 popped, 0x07 stored at tail, o_ovfl unchanged.
REQ-035 i_reset_n pulsed low with register full and FIFOs non-empty -> all outputs 0 immediately, without a clock edge.
